// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes and special register specifiers.
// Pure constants; no logic.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] R_RSP    = 4'h4;
  localparam logic [3:0] R_NONE   = 4'hF;

endpackage

// File: rtl/y86_fetch.sv
// Splits a 10-byte instruction window into fields, valC, valP and legality flags.
// Latency: purely combinational; no backpressure.
module y86_fetch
  import y86_pkg::*;
#(
  parameter int unsigned IMEM_SIZE = 20480
) (
  input  logic [63:0] pc_i,
  input  logic [0:79] instr_i,
  output logic [3:0]  icode_o,
  output logic [3:0]  ifun_o,
  output logic [3:0]  ra_o,
  output logic [3:0]  rb_o,
  output logic [63:0] valc_o,
  output logic [63:0] valp_o,
  output logic        valid_o,
  output logic        halt_o,
  output logic        mem_error_o
);

  logic [7:0] b [10];
  logic [3:0] len;

  // Byte k of the window occupies instr_i[8k : 8k+7], most significant bit first.
  always_comb begin
    for (int k = 0; k < 10; k++) b[k] = instr_i[8*k +: 8];
  end

  assign icode_o     = b[0][7:4];
  assign ifun_o      = b[0][3:0];
  assign halt_o      = (icode_o == I_HALT);
  assign mem_error_o = (pc_i >= 64'(IMEM_SIZE));
  assign valp_o      = pc_i + 64'(len);

  always_comb begin
    ra_o = R_NONE;
    rb_o = R_NONE;
    case (icode_o)
      I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
        ra_o = b[1][7:4];
        rb_o = b[1][3:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    valc_o = '0;
    case (icode_o)
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: valc_o = {b[9], b[8], b[7], b[6], b[5], b[4], b[3], b[2]};
      I_JXX, I_CALL:                valc_o = {b[8], b[7], b[6], b[5], b[4], b[3], b[2], b[1]};
      default: ;
    endcase
  end

  // Unknown icodes advance by one byte so the enclosing core can still make progress.
  always_comb begin
    len = 4'd1;
    case (icode_o)
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: len = 4'd2;
      I_JXX, I_CALL:                    len = 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     len = 4'd10;
      default:                          len = 4'd1;
    endcase
  end

  always_comb begin
    valid_o = 1'b0;
    case (icode_o)
      I_RRMOVQ, I_JXX: valid_o = (ifun_o <= 4'd6);
      I_OPQ:           valid_o = (ifun_o <= 4'd3);
      I_HALT, I_NOP, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ:
                       valid_o = (ifun_o == 4'd0);
      default:         valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/y86_regfile.sv
// 15x64 register file, two combinational read ports, two write ports, sync reset.
// Latency: reads same cycle, writes visible next cycle; no backpressure.
module y86_regfile
  import y86_pkg::*;
(
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [3:0]   src_a_i,
  input  logic [3:0]   src_b_i,
  input  logic [3:0]   dst_e_i,
  input  logic [3:0]   dst_m_i,
  input  logic [63:0]  val_e_i,
  input  logic [63:0]  val_m_i,
  output logic [63:0]  val_a_o,
  output logic [63:0]  val_b_o,
  output logic [959:0] regs_o
);

  logic [63:0] regs_q [15];
  logic [63:0] regs_d [15];

  // Port M is applied after port E so popq %rsp keeps the loaded value.
  always_comb begin
    for (int i = 0; i < 15; i++) begin
      regs_d[i] = regs_q[i];
      if (dst_e_i == 4'(i)) regs_d[i] = val_e_i;
      if (dst_m_i == 4'(i)) regs_d[i] = val_m_i;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 15; i++) begin
      if (reset_i) regs_q[i] <= '0;
      else         regs_q[i] <= regs_d[i];
    end
  end

  // R_NONE matches no entry and therefore reads as zero.
  always_comb begin
    val_a_o = '0;
    val_b_o = '0;
    regs_o  = '0;
    for (int i = 0; i < 15; i++) begin
      if (src_a_i == 4'(i)) val_a_o = regs_q[i];
      if (src_b_i == 4'(i)) val_b_o = regs_q[i];
      regs_o[64*i +: 64] = regs_q[i];
    end
  end

endmodule

// File: rtl/fetch_decode_writeback.sv
// SEQ Y86-64 front end: fetch split, decode reads, clocked write-back.
// Latency: fetch/decode combinational, write-back at the rising edge; no handshakes.
module fetch_decode_writeback
  import y86_pkg::*;
#(
  parameter int unsigned IMEM_SIZE = 20480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] PC,
  input  logic [0:79] instr,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic        cnd,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic        ins_mem_error,
  output logic        valid_instr,
  output logic        halt,
  output logic [63:0] reg_0,
  output logic [63:0] reg_1,
  output logic [63:0] reg_2,
  output logic [63:0] reg_3,
  output logic [63:0] reg_4,
  output logic [63:0] reg_5,
  output logic [63:0] reg_6,
  output logic [63:0] reg_7,
  output logic [63:0] reg_8,
  output logic [63:0] reg_9,
  output logic [63:0] reg_10,
  output logic [63:0] reg_11,
  output logic [63:0] reg_12,
  output logic [63:0] reg_13,
  output logic [63:0] reg_14
);

  logic [3:0]   src_a, src_b, dst_e, dst_m;
  logic [959:0] regs_flat;

  y86_fetch #(.IMEM_SIZE(IMEM_SIZE)) u_fetch (
    .pc_i        (PC),
    .instr_i     (instr),
    .icode_o     (icode),
    .ifun_o      (ifun),
    .ra_o        (rA),
    .rb_o        (rB),
    .valc_o      (valC),
    .valp_o      (valP),
    .valid_o     (valid_instr),
    .halt_o      (halt),
    .mem_error_o (ins_mem_error)
  );

  always_comb begin
    src_a = R_NONE;
    src_b = R_NONE;
    case (icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = rA;
      I_RET, I_POPQ:                      src_a = R_RSP;
      default: ;
    endcase
    case (icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:      src_b = rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ: src_b = R_RSP;
      default: ;
    endcase
  end

  // A not-taken cmovXX degrades to a no-write instruction.
  always_comb begin
    dst_e = R_NONE;
    dst_m = R_NONE;
    case (icode)
      I_IRMOVQ, I_OPQ:                dst_e = rB;
      I_RRMOVQ:                       dst_e = cnd ? rB : R_NONE;
      I_CALL, I_RET, I_PUSHQ, I_POPQ: dst_e = R_RSP;
      default: ;
    endcase
    case (icode)
      I_MRMOVQ, I_POPQ: dst_m = rA;
      default: ;
    endcase
  end

  y86_regfile u_regfile (
    .clk_i   (clk),
    .reset_i (reset),
    .src_a_i (src_a),
    .src_b_i (src_b),
    .dst_e_i (dst_e),
    .dst_m_i (dst_m),
    .val_e_i (valE),
    .val_m_i (valM),
    .val_a_o (valA),
    .val_b_o (valB),
    .regs_o  (regs_flat)
  );

  assign reg_0  = regs_flat[0*64  +: 64];
  assign reg_1  = regs_flat[1*64  +: 64];
  assign reg_2  = regs_flat[2*64  +: 64];
  assign reg_3  = regs_flat[3*64  +: 64];
  assign reg_4  = regs_flat[4*64  +: 64];
  assign reg_5  = regs_flat[5*64  +: 64];
  assign reg_6  = regs_flat[6*64  +: 64];
  assign reg_7  = regs_flat[7*64  +: 64];
  assign reg_8  = regs_flat[8*64  +: 64];
  assign reg_9  = regs_flat[9*64  +: 64];
  assign reg_10 = regs_flat[10*64 +: 64];
  assign reg_11 = regs_flat[11*64 +: 64];
  assign reg_12 = regs_flat[12*64 +: 64];
  assign reg_13 = regs_flat[13*64 +: 64];
  assign reg_14 = regs_flat[14*64 +: 64];

endmodule

// File: tb/tb_fetch_decode_writeback.sv
// Bench: directed Y86 program with literal expectations, then random instruction windows
// checked every cycle against a table-driven instruction-set model.
module tb_fetch_decode_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] PC;
  logic [0:79] instr;
  logic [63:0] valE, valM;
  logic        cnd;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP, valA, valB;
  logic        ins_mem_error, valid_instr, halt;
  logic [63:0] reg_0, reg_1, reg_2, reg_3, reg_4, reg_5, reg_6, reg_7;
  logic [63:0] reg_8, reg_9, reg_10, reg_11, reg_12, reg_13, reg_14;
  logic [63:0] r_out [15];

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  fetch_decode_writeback #(.IMEM_SIZE(20480)) dut (
    .clk(clk), .reset(reset), .PC(PC), .instr(instr), .valE(valE), .valM(valM), .cnd(cnd),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .valA(valA), .valB(valB), .ins_mem_error(ins_mem_error), .valid_instr(valid_instr),
    .halt(halt),
    .reg_0(reg_0), .reg_1(reg_1), .reg_2(reg_2), .reg_3(reg_3), .reg_4(reg_4),
    .reg_5(reg_5), .reg_6(reg_6), .reg_7(reg_7), .reg_8(reg_8), .reg_9(reg_9),
    .reg_10(reg_10), .reg_11(reg_11), .reg_12(reg_12), .reg_13(reg_13), .reg_14(reg_14)
  );

  assign r_out[0]  = reg_0;   assign r_out[1]  = reg_1;   assign r_out[2]  = reg_2;
  assign r_out[3]  = reg_3;   assign r_out[4]  = reg_4;   assign r_out[5]  = reg_5;
  assign r_out[6]  = reg_6;   assign r_out[7]  = reg_7;   assign r_out[8]  = reg_8;
  assign r_out[9]  = reg_9;   assign r_out[10] = reg_10;  assign r_out[11] = reg_11;
  assign r_out[12] = reg_12;  assign r_out[13] = reg_13;  assign r_out[14] = reg_14;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] mreg [15];
  int len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
  int fn_max  [16] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, -1, -1, -1, -1};

  function automatic logic [63:0] mread(input logic [3:0] r);
    return (r == 4'hF) ? 64'd0 : mreg[r];
  endfunction

  logic [7:0]  mb [10];
  logic [3:0]  e_ic, e_fn, e_ra, e_rb, e_sa, e_sb, e_de, e_dm;
  logic [63:0] e_c, e_p;
  logic        e_valid;
  int          off;

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 10; k++) mb[k] = instr[8*k +: 8];
      e_ic = mb[0][7:4];
      e_fn = mb[0][3:0];
      if (e_ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) begin
        e_ra = mb[1][7:4];
        e_rb = mb[1][3:0];
      end else begin
        e_ra = 4'hF;
        e_rb = 4'hF;
      end
      off = (e_ic inside {4'h3, 4'h4, 4'h5}) ? 2 : (e_ic inside {4'h7, 4'h8}) ? 1 : 0;
      e_c = 64'd0;
      if (off != 0)
        for (int k = 7; k >= 0; k--) e_c = {e_c[55:0], mb[off + k]};
      e_p     = PC + 64'(len_tab[e_ic]);
      e_valid = (int'(e_fn) <= fn_max[e_ic]);
      e_sa = (e_ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? e_ra :
             (e_ic inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
      e_sb = (e_ic inside {4'h4, 4'h5, 4'h6}) ? e_rb :
             (e_ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
      e_de = (e_ic inside {4'h3, 4'h6} || (e_ic == 4'h2 && cnd)) ? e_rb :
             (e_ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
      e_dm = (e_ic inside {4'h5, 4'hB}) ? e_ra : 4'hF;

      chk("cmp_icode", 64'(icode), 64'(e_ic));
      chk("cmp_ifun",  64'(ifun),  64'(e_fn));
      chk("cmp_rA",    64'(rA),    64'(e_ra));
      chk("cmp_rB",    64'(rB),    64'(e_rb));
      chk("cmp_valC",  valC, e_c);
      chk("cmp_valP",  valP, e_p);
      chk("cmp_valA",  valA, mread(e_sa));
      chk("cmp_valB",  valB, mread(e_sb));
      chk("cmp_valid", 64'(valid_instr), 64'(e_valid));
      chk("cmp_halt",  64'(halt), 64'(e_ic == 4'h0));
      chk("cmp_memerr", 64'(ins_mem_error), 64'(PC >= 64'd20480));
      for (int i = 0; i < 15; i++) chk($sformatf("cmp_reg%0d", i), r_out[i], mreg[i]);

      if (reset) begin
        for (int i = 0; i < 15; i++) mreg[i] = 64'd0;
      end else begin
        if (e_de != 4'hF) mreg[e_de] = valE;
        if (e_dm != 4'hF) mreg[e_dm] = valM;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [63:0] pc, input logic [79:0] ins, input logic [63:0] e,
                      input logic [63:0] m, input logic c, input logic r);
    @(posedge clk);
    #1;
    PC = pc; instr = ins; valE = e; valM = m; cnd = c; reset = r;
    #1;
  endtask

  initial begin
    logic [79:0] rnd;
    logic [3:0]  ric, rfn;
    for (int i = 0; i < 15; i++) mreg[i] = 64'd0;
    reset = 1'b1; PC = '0; instr = 80'h1000_0000_0000_0000_0000;
    valE = '0; valM = '0; cnd = 1'b0;

    step(0, 80'h1000_0000_0000_0000_0000, 0, 0, 0, 1);
    cmp_en = 1'b1;
    step(0, 80'h1000_0000_0000_0000_0000, 0, 0, 0, 1);
    chk("rst_reg3", reg_3, 64'd0);

    // irmovq $0x100,%rbx
    step(0, 80'h30F3_0001_0000_0000_0000, 64'h100, 0, 0, 0);
    chk("irm_rB", 64'(rB), 64'h3);
    chk("irm_rA", 64'(rA), 64'hF);
    chk("irm_valC", valC, 64'h100);
    chk("irm_valP", valP, 64'd10);
    chk("irm_valid", 64'(valid_instr), 64'd1);
    // irmovq $0x200,%rdx
    step(10, 80'h30F2_0002_0000_0000_0000, 64'h200, 0, 0, 0);
    chk("irm_reg3", reg_3, 64'h100);
    // addq %rdx,%rbx
    step(20, 80'h6023_0000_0000_0000_0000, 64'h300, 0, 0, 0);
    chk("add_valA", valA, 64'h200);
    chk("add_valB", valB, 64'h100);
    chk("add_valP", valP, 64'd22);
    // cmovle %rbx,%rsp, not taken then taken
    step(22, 80'h2134_0000_0000_0000_0000, 64'd5, 0, 0, 0);
    chk("add_reg3", reg_3, 64'h300);
    step(24, 80'h2134_0000_0000_0000_0000, 64'd5, 0, 1, 0);
    chk("cmov_nt_reg4", reg_4, 64'd0);
    // popq %rsp
    step(26, 80'hB04F_0000_0000_0000_0000, 64'd8, 64'h55, 0, 0);
    chk("cmov_t_reg4", reg_4, 64'd5);
    chk("pop_valA", valA, 64'd5);
    chk("pop_valB", valB, 64'd5);
    // call 0x27 ; ret
    step(64'h40, 80'h8027_0000_0000_0000_0000, 64'h4D, 0, 0, 0);
    chk("pop_reg4", reg_4, 64'h55);
    chk("call_valC", valC, 64'h27);
    chk("call_valP", valP, 64'h49);
    chk("call_valB", valB, 64'h55);
    step(64'h49, 80'h9000_0000_0000_0000_0000, 64'h55, 64'h1234, 0, 0);
    chk("ret_valP", valP, 64'h4A);
    // flags
    step(64'h100, 80'hC000_0000_0000_0000_0000, 0, 0, 0, 0);
    chk("bad_valid", 64'(valid_instr), 64'd0);
    step(64'h100, 80'h0000_0000_0000_0000_0000, 0, 0, 0, 0);
    chk("halt_flag", 64'(halt), 64'd1);
    step(64'd20480, 80'h1000_0000_0000_0000_0000, 0, 0, 0, 0);
    chk("memerr_at", 64'(ins_mem_error), 64'd1);
    step(64'd20479, 80'h1000_0000_0000_0000_0000, 0, 0, 0, 0);
    chk("memerr_below", 64'(ins_mem_error), 64'd0);
    step(64'hFFFF_FFFF_FFFF_FFFF, 80'h1000_0000_0000_0000_0000, 0, 0, 0, 0);
    chk("valP_wrap", valP, 64'd0);
    // reset beats a pending irmovq write
    step(0, 80'h30F3_0001_0000_0000_0000, 64'hDEAD, 0, 0, 1);
    step(0, 80'h1000_0000_0000_0000_0000, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) chk($sformatf("rst_wr_reg%0d", i), r_out[i], 64'd0);

    // random program
    for (int n = 0; n < 2500; n++) begin
      rnd = {$urandom, $urandom, $urandom};
      ric = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 11)) : 4'($urandom_range(0, 15));
      rfn = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      rnd[79:72] = {ric, rfn};
      step(($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 24000)),
           rnd, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
           ($urandom_range(0, 63) == 0));
    end
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_decode_writeback.md
# fetch_decode_writeback

Front end of the single-cycle (SEQ) Y86-64 datapath: combinational fetch/split of a 10-byte instruction window, combinational decode (register-file reads) and clocked write-back of the 15 architectural registers. The enclosing processor presents `instr` for the current `PC`, consumes `icode/ifun/valC/valP/valA/valB`, and returns `valE`, `valM` and `cnd` from execute/memory in the same cycle.

## Interface
- `IMEM_SIZE`, default 20480: instruction-memory size in bytes; bounds `ins_mem_error`.
- One clock; reset is synchronous and active-high.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high; clears the register file.
- `PC` in 64: address of the current instruction.
- `instr` in 80, `[0:79]`: bytes PC..PC+9, with byte PC at bits `[0:7]`.
- `valE`, `valM` in 64: execute result and memory read data.
- `cnd` in 1: condition result; gates cmovXX write-back.
- `icode`, `ifun` out 4: high and low nibble of byte 0.
- `rA`, `rB` out 4: register specifiers; 0xF when the instruction has no register byte.
- `valC` out 64: constant field.
- `valP` out 64: PC + instruction length.
- `valA`, `valB` out 64: decode read data.
- `ins_mem_error` out 1: `PC >= IMEM_SIZE`.
- `valid_instr` out 1: legal icode/ifun.
- `halt` out 1: `icode == 0`.
- `reg_0`..`reg_14` out 64 each: live contents of registers 0–14.

## Operation
- Byte0 = {icode, ifun}.
- Register byte (byte1) = {rA, rB} for rrmovq/cmovXX(2), irmovq(3), rmmovq(4), mrmovq(5), OPq(6), pushq(A), popq(B); all other icodes give rA = rB = 0xF.
- valC is little-endian:
  - irmovq/rmmovq/mrmovq: valC = {byte9..byte2}.
  - jXX(7)/call(8): valC = {byte8..byte1}.
  - All others: valC = 0.
- Instruction lengths for valP:
  - 1 byte: halt(0), nop(1), ret(9).
  - 2 bytes: 2, 6, A, B.
  - 9 bytes: 7, 8.
  - 10 bytes: 3, 4, 5.
  - Invalid icode: valP = PC + 1.
  - valP arithmetic is modulo 2^64.
- `valid_instr` = 0 when any of:
  - icode > 0xB;
  - icode 2 or 7 with ifun > 6;
  - icode 6 with ifun > 3;
  - any other icode with ifun ≠ 0.
- Other fetch flags:
  - `halt` = (icode == 0), independent of the error flags.
  - `ins_mem_error` does not alter the decoded fields.
- srcA:
  - rA for icode 2, 4, 6, A;
  - 4 (%rsp) for icode 9, B;
  - else 0xF.
- srcB:
  - rB for icode 4, 5, 6;
  - 4 for icode 8, 9, A, B;
  - else 0xF.
- Reads: valA = reg[srcA], valB = reg[srcB]; a source of 0xF reads 0.
- dstE:
  - rB for irmovq and OPq;
  - rB for cmovXX only when `cnd` = 1;
  - 4 for icode 8, 9, A, B;
  - else 0xF.
- dstM: rA for mrmovq and popq, else 0xF.
- Write-back: on the rising edge, reg[dstE] ← valE and reg[dstM] ← valM; a destination of 0xF writes nothing.
- If dstE == dstM, valM wins (popq %rsp).
- Writes happen regardless of `valid_instr`, `ins_mem_error` or `halt`; the enclosing processor stops the clock or PC.

## Timing
- Fetch and decode are purely combinational; read data and fields are valid in the same cycle as `PC`/`instr`.
- Write-back commits at the rising edge ending the instruction's cycle; the written value is visible on `reg_n` and on reads in the next cycle.
- No read-during-write bypass: same-cycle reads return the old value.
- Reset takes priority over write-back: with `reset` high at an edge, all 15 registers become 0 and no write occurs.
- Reset mid-program takes effect at the next edge.
- No handshakes; single-cycle latency.

## Structure
- Shared package `y86_pkg`:
  - icode constants: I_HALT=0, I_NOP=1, I_RRMOVQ=2, I_IRMOVQ=3, I_RMMOVQ=4, I_MRMOVQ=5, I_OPQ=6, I_JXX=7, I_CALL=8, I_RET=9, I_PUSHQ=A, I_POPQ=B;
  - R_RSP=4, R_NONE=F.
- Sub-modules:
  - `y86_fetch`: combinational split, valC, valP and flags.
  - `y86_regfile`: 15×64 array, 2 read ports, 2 write ports, synchronous reset.
- The top module wires the two together and holds the srcA/srcB/dstE/dstM logic.

## Test plan
- Reset, then irmovq $0x100,%rbx (30 F3 00 01 00 00 00 00 00 00) at PC 0:
  - fetch: rB=3, rA=F, valC=0x100, valP=10, valid_instr=1;
  - drive valE=0x100 → after the edge reg_3 = 0x100.
- With reg_2=0x200 and reg_3=0x100, addq %rdx,%rbx (60 23) at PC 20 → valA=0x200, valB=0x100, valP=22; drive valE=0x300 → reg_3 = 0x300.
- cmovle %rbx,%rsp (21 34) with valE=5:
  - cnd=0 → reg_4 unchanged;
  - cnd=1 → reg_4 = 5.
- popq %rsp (B0 4F) with valE=8, valM=0x55 → reg_4 = 0x55 (dstM wins); valA = valB = old reg_4.
- call 0x27 (80 27 00…00) → valC=0x27, valP=PC+9, valB=reg_4; ret (90) → valP=PC+1.
- Error and control flags:
  - byte0 = C0 → valid_instr=0;
  - byte0 = 00 → halt=1;
  - PC=20480 → ins_mem_error=1;
  - reset asserted together with a pending write → all reg_n = 0.
